// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle MIPS control unit and its datapath.
// The control unit is the master: it consumes opcode/zero and drives every mux, enable and debug output.
interface multicycle_control_if;
    logic [5:0]  opcode;
    logic        zero;
    logic        pc_en;
    logic        iord;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_src;
    logic        ext_zero;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] retired;

    modport master (
        input  opcode, zero,
        output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, ext_zero, illegal, state, retired
    );

    modport slave (
        output opcode, zero,
        input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, ext_zero, illegal, state, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the datapath controls as Moore outputs and counts retired instructions.
//   state   | meaning
//   FETCH   | read instruction, PC <= PC+4
//   DECODE  | read registers, branch target into ALUOut
//   MEMADR  | lw/sw effective address
//   MEMRD   | data memory read
//   MEMWB   | load writeback
//   MEMWR   | data memory write
//   RTYPEEX | R-type ALU operation
//   RTYPEWB | R-type writeback to rd
//   BEQEX   | compare, conditional PC load
//   IMMEX   | immediate ALU operation
//   IMMWB   | immediate writeback to rt
//   JEX     | jump
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    state_e      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        pc_write;
    logic        branch;
    logic        is_mem;
    logic        is_imm;
    logic        is_legal;

    always_comb begin
        is_mem   = (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
        is_imm   = (bus.opcode == OP_ADDI) || (bus.opcode == OP_SLTI) ||
                   (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);
        is_legal = is_mem || is_imm || (bus.opcode == OP_R) ||
                   (bus.opcode == OP_BEQ) || (bus.opcode == OP_J);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d        = S_FETCH;
        retired_d      = retired_q;
        pc_write       = 1'b0;
        branch         = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.pc_src     = 2'b00;
        bus.illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                state_d       = S_DECODE;
                bus.ir_write  = 1'b1;
                bus.alu_src_b = 2'b01;
                pc_write      = 1'b1;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                if (is_mem)                      state_d = S_MEMADR;
                else if (bus.opcode == OP_R)     state_d = S_RTYPEEX;
                else if (bus.opcode == OP_BEQ)   state_d = S_BEQEX;
                else if (is_imm)                 state_d = S_IMMEX;
                else if (bus.opcode == OP_J)     state_d = S_JEX;
                else                             state_d = S_FETCH;
                bus.illegal = !is_legal;
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
            end
            S_BEQEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                branch        = 1'b1;
            end
            S_IMMEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = 2'b11;
                state_d       = S_IMMWB;
            end
            S_IMMWB: begin
                bus.reg_write = 1'b1;
            end
            S_JEX: begin
                bus.pc_src = 2'b10;
                pc_write   = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Every final state of a legal instruction returns to FETCH and retires it.
        case (state_q)
            S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_IMMWB, S_JEX:
                retired_d = retired_q + 32'd1;
            default: retired_d = retired_q;
        endcase
    end

    assign bus.pc_en    = pc_write | (branch & bus.zero);
    assign bus.ext_zero = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);
    assign bus.state    = state_q;
    assign bus.retired  = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed and randomized instruction
// streams checked cycle by cycle against a per-instruction-class reference model.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   model_retired = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       ext_zero;
        logic       illegal;
    } outs_t;

    outs_t obs;
    assign obs = {bus.pc_en, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
                  bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                  bus.alu_op, bus.pc_src, bus.ext_zero, bus.illegal};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                           JMP = 6'b000010, ADDI = 6'b001000, SLTI = 6'b001010,
                           ANDI = 6'b001100, ORI = 6'b001101;

    function automatic bit is_legal(input logic [5:0] op);
        return op == LW || op == SW || op == RT || op == BEQ || op == JMP ||
               op == ADDI || op == SLTI || op == ANDI || op == ORI;
    endfunction

    function automatic int cpi(input logic [5:0] op);
        case (op)
            LW:                     return 5;
            SW, RT, ADDI, SLTI,
            ANDI, ORI:              return 4;
            BEQ, JMP:               return 3;
            default:                return 2;
        endcase
    endfunction

    // State visited at step i of an instruction, by instruction class.
    function automatic logic [3:0] exp_state(input logic [5:0] op, input int i);
        logic [3:0] path [5];
        case (op)
            LW:                     path = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            SW:                     path = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
            RT:                     path = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
            BEQ:                    path = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0};
            JMP:                    path = '{4'd0, 4'd1, 4'd11, 4'd0, 4'd0};
            ADDI, SLTI, ANDI, ORI:  path = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
            default:                path = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
        endcase
        return path[i];
    endfunction

    function automatic outs_t exp_outs(input logic [3:0] st, input logic [5:0] op, input logic z);
        outs_t o = '0;
        o.ext_zero = (op == ANDI) || (op == ORI);
        case (st)
            4'd0:  begin o.ir_write = 1; o.alu_src_b = 2'b01; o.pc_en = 1; end
            4'd1:  begin o.alu_src_b = 2'b11; o.illegal = !is_legal(op); end
            4'd2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4'd3:  o.iord = 1;
            4'd4:  begin o.mem_to_reg = 1; o.reg_write = 1; end
            4'd5:  begin o.iord = 1; o.mem_write = 1; end
            4'd6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            4'd7:  begin o.reg_dst = 1; o.reg_write = 1; end
            4'd8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_en = z; end
            4'd9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 2'b11; end
            4'd10: o.reg_write = 1;
            4'd11: begin o.pc_src = 2'b10; o.pc_en = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic test_reset();
        outs_t e;
        reset = 1'b1;
        bus.opcode = RT;
        bus.zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_retired = 0;
        @(negedge clk);
        e = exp_outs(4'd0, bus.opcode, bus.zero);
        checks++;
        if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_outs got=%h exp=%h", obs, e); end
        checks++;
        if (bus.retired !== 32'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", bus.retired); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd1) begin errors++; $display("FAIL reset_release_state got=%0d exp=1", bus.state); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [5:0] ops [12] = '{LW, SW, RT, BEQ, BEQ, JMP, ADDI, SLTI, ANDI, ORI, 6'b111111, 6'b010101};
        logic       zs  [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        outs_t e;
        logic [3:0] st;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < cpi(ops[k]); i++) begin
                bus.opcode = ops[k];
                bus.zero = zs[k];
                @(negedge clk);
                st = exp_state(ops[k], i);
                e = exp_outs(st, ops[k], zs[k]);
                checks++;
                if (bus.state !== st) begin
                    errors++;
                    $display("FAIL dir_state op=%b step=%0d got=%0d exp=%0d", ops[k], i, bus.state, st);
                end
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL dir_outs op=%b step=%0d got=%h exp=%h", ops[k], i, obs, e);
                end
                @(posedge clk);
                #1;
            end
            if (is_legal(ops[k])) model_retired++;
            checks++;
            if (bus.retired !== 32'(model_retired)) begin
                errors++;
                $display("FAIL dir_retired op=%b got=%0d exp=%0d", ops[k], bus.retired, model_retired);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] pool [9] = '{LW, SW, RT, BEQ, JMP, ADDI, SLTI, ANDI, ORI};
        logic [5:0] op;
        logic [5:0] drive;
        logic       z;
        outs_t e;
        logic [3:0] st;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(3) != 0) op = pool[$urandom_range(8)];
            else                        op = 6'($urandom);
            for (int i = 0; i < cpi(op); i++) begin
                // Opcode is only guaranteed in DECODE/MEMADR; scramble it elsewhere.
                drive = (i == 1 || i == 2) ? op : 6'($urandom);
                z = 1'($urandom);
                bus.opcode = drive;
                bus.zero = z;
                @(negedge clk);
                st = exp_state(op, i);
                e = exp_outs(st, drive, z);
                checks++;
                if (bus.state !== st) begin
                    errors++;
                    $display("FAIL rnd_state op=%b step=%0d got=%0d exp=%0d", op, i, bus.state, st);
                end
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL rnd_outs op=%b step=%0d got=%h exp=%h", op, i, obs, e);
                end
                @(posedge clk);
                #1;
            end
            if (is_legal(op)) model_retired++;
            checks++;
            if (bus.retired !== 32'(model_retired)) begin
                errors++;
                $display("FAIL rnd_retired op=%b got=%0d exp=%0d", op, bus.retired, model_retired);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] st;
        bus.opcode = LW;
        bus.zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) reset = 1'b1;
            @(negedge clk);
            st = exp_state(LW, i);
            checks++;
            if (bus.state !== st) begin
                errors++;
                $display("FAIL mid_state step=%0d got=%0d exp=%0d", i, bus.state, st);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        model_retired = 0;
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd0) begin errors++; $display("FAIL mid_abort_state got=%0d exp=0", bus.state); end
        checks++;
        if (bus.retired !== 32'd0) begin errors++; $display("FAIL mid_abort_retired got=%0d exp=0", bus.retired); end
        checks++;
        if (obs !== exp_outs(4'd0, LW, 1'b0)) begin
            errors++;
            $display("FAIL mid_abort_outs got=%h exp=%h", obs, exp_outs(4'd0, LW, 1'b0));
        end
        bus.opcode = 6'b111111;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL mid_no_write got=%b exp=0", bus.reg_write); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
